ofm_axi_write_master: RTL

Downstream AXI4 write master for the convolution engine's output-feature-map path. It takes a write request (base, offset, byte size) and the 512-bit OFM stream produced by the engine's flattener. It splits the transfer into AXI4 INCR bursts that never cross a 4 KB boundary and never exceed a configurable length. It pulses `done` after the last write response; that pulse is what the engine consumes as `ofm_done`.

---
 rtl/ofm_axi_write_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ofm_axi_write_master.sv
// ofm_axi_write_master
// ---------------------------------------------------------------------------
// AXI4 write master for the output-feature-map path. It accepts one write
// request (base + offset, byte size) and moves the engine's 512-bit OFM stream
// to memory as a series of INCR bursts. Each burst is limited to MAX_BURST_LEN
// beats and never crosses a 4 KB page. Only one burst is in flight at a time.
// The W channel is a combinational pass-through of the stream.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req                         start request (accepted only when idle)
//   addr_base, addr_offset      destination = base + offset (64-byte aligned)
//   xfer_size                   byte count, multiple of 64
//   done                        one-cycle pulse after the final write response
//   busy                        high whenever a transfer is in progress
//   err                         sticky, set by any non-OKAY BRESP; cleared on req
//   s_tvalid/s_tready/s_tdata   OFM stream slave
//   m_axi_aw*, m_axi_w*, m_axi_b*   AXI4 write channels
// ---------------------------------------------------------------------------
module ofm_axi_write_master #(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 512,
    parameter int MAX_BURST_LEN = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic [ADDR_WIDTH-1:0]   addr_base,
    input  logic [ADDR_WIDTH-1:0]   addr_offset,
    input  logic [63:0]             xfer_size,
    output logic                    done,
    output logic                    busy,
    output logic                    err,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    input  logic [1:0]              m_axi_bresp
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_AW   = 3'd2;
    localparam logic [2:0] S_W    = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;        // start address of the next burst
    logic [63:0]           r_beats_left;  // beats not yet covered by a burst
    logic [8:0]            r_len;         // beats in the current burst (1..256)
    logic [8:0]            r_beat_cnt;    // beats accepted in the current burst
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [7:0]            r_awlen;
    logic                  r_err;

    logic [12:0]           w_room_bytes;
    logic [6:0]            w_room_beats;
    logic [8:0]            w_len;
    logic                  w_w_hs;
    logic                  w_last_beat;
    logic                  w_unused_size_lsbs;

    // Byte size is a multiple of 64, so its low bits carry no information.
    assign w_unused_size_lsbs = ^xfer_size[5:0];

    // Bytes left before the next 4 KB page; with a 64-byte aligned address
    // this is 64..4096, i.e. 1..64 beats.
    assign w_room_bytes = 13'd4096 - {1'b0, r_addr[11:0]};
    assign w_room_beats = w_room_bytes[12:6];

    // Burst length = min(beats_left, MAX_BURST_LEN, beats to page end).
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_len = 9'(MAX_BURST_LEN);
        if ({2'b00, w_room_beats} < w_len) begin
            w_len = {2'b00, w_room_beats};
        end
        if (r_beats_left < {55'd0, w_len}) begin
            w_len = r_beats_left[8:0];
        end
    end

    assign w_w_hs      = (r_state == S_W) && s_tvalid && m_axi_wready;
    assign w_last_beat = (r_beat_cnt == (r_len - 9'd1));

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_beats_left <= '0;
            r_len        <= '0;
            r_beat_cnt   <= '0;
            r_awaddr     <= '0;
            r_awlen      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_addr       <= addr_base + addr_offset;
                        r_beats_left <= {6'd0, xfer_size[63:6]};
                        r_err        <= 1'b0;
                        r_state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_beats_left == 64'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_len    <= w_len;
                        r_awaddr <= r_addr;
                        r_awlen  <= 8'(w_len - 9'd1);
                        r_state  <= S_AW;
                    end
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        r_beat_cnt <= '0;
                        r_state    <= S_W;
                    end
                end
                S_W: begin
                    if (w_w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 9'd1;
                        if (w_last_beat) begin
                            r_state <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        r_err        <= r_err | (m_axi_bresp != 2'b00);
                        r_addr       <= r_addr + {{(ADDR_WIDTH-15){1'b0}}, r_len, 6'd0};
                        r_beats_left <= r_beats_left - {55'd0, r_len};
                        r_state      <= S_CALC;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Control outputs decode straight from the state, so they are all low in
    // reset and the W channel adds no latency to the stream.
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign err           = r_err;

    assign m_axi_awvalid = (r_state == S_AW);
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awsize  = 3'd6;
    assign m_axi_awburst = 2'b01;

    assign m_axi_wvalid  = (r_state == S_W) && s_tvalid;
    assign s_tready      = (r_state == S_W) && m_axi_wready;
    assign m_axi_wlast   = (r_state == S_W) && w_last_beat;
    assign m_axi_wdata   = s_tdata;
    assign m_axi_wstrb   = '1;

    assign m_axi_bready  = (r_state == S_B);

endmodule
